// File: rtl/puzzle_pkg.sv
// Shared keypad definitions: key codes used by the scanner and its consumers,
// plus the matrix geometry and the position-to-code lookup.
package puzzle_pkg;

  localparam logic [3:0] KEY_0    = 4'd0;
  localparam logic [3:0] KEY_1    = 4'd1;
  localparam logic [3:0] KEY_2    = 4'd2;
  localparam logic [3:0] KEY_3    = 4'd3;
  localparam logic [3:0] KEY_4    = 4'd4;
  localparam logic [3:0] KEY_5    = 4'd5;
  localparam logic [3:0] KEY_6    = 4'd6;
  localparam logic [3:0] KEY_7    = 4'd7;
  localparam logic [3:0] KEY_8    = 4'd8;
  localparam logic [3:0] KEY_9    = 4'd9;
  localparam logic [3:0] KEY_STAR = 4'd10;
  localparam logic [3:0] KEY_HASH = 4'd11;

  localparam int KP_ROWS = 4;
  localparam int KP_COLS = 3;
  localparam int KP_KEYS = KP_ROWS * KP_COLS;

  // Snapshot bit index is row*3 + col.
  function automatic logic [3:0] kp_code_at(input int idx);
    logic [3:0] code;
    case (idx)
      0:       code = KEY_1;
      1:       code = KEY_2;
      2:       code = KEY_3;
      3:       code = KEY_4;
      4:       code = KEY_5;
      5:       code = KEY_6;
      6:       code = KEY_7;
      7:       code = KEY_8;
      8:       code = KEY_9;
      9:       code = KEY_STAR;
      10:      code = KEY_0;
      11:      code = KEY_HASH;
      default: code = KEY_0;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/keypad_encoder.sv
// Classifies a 12-bit key snapshot (1 = pressed) as no key, one key with
// its code, or several keys.
module keypad_encoder
  import puzzle_pkg::*;
(
  input  logic [KP_KEYS-1:0] i_snap,
  output logic [3:0]         o_code,
  output logic               o_none,
  output logic               o_multi
);

  logic [3:0] w_count;

  // Count pressed keys and report the code of the lowest pressed position.
  always_comb begin
    w_count = 4'd0;
    o_code  = KEY_0;
    for (int i = KP_KEYS - 1; i >= 0; i--) begin
      if (i_snap[i]) begin
        w_count = w_count + 4'd1;
        o_code  = kp_code_at(i);
      end
    end
    o_none  = (w_count == 4'd0);
    o_multi = (w_count >= 4'd2);
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x3 matrix keypad scanner: column strobing, row synchronisation, per-frame
// snapshot and press/release debouncing with a one-cycle accept pulse.
module keypad_scanner
  import puzzle_pkg::*;
#(
  parameter int SCAN_DIV        = 1000,
  parameter int DEBOUNCE_FRAMES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key_row,
  output logic [2:0] key_col,
  output logic       key_valid,
  output logic [3:0] key_value,
  output logic       key_held
);

  localparam int                 DIV_W     = $clog2(SCAN_DIV);
  localparam logic [DIV_W-1:0]   DIV_LAST  = DIV_W'(SCAN_DIV - 1);
  localparam int                 CNT_W     = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [CNT_W-1:0]   CNT_DONE  = CNT_W'(DEBOUNCE_FRAMES);
  localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]   CNT_MAX   = '1;
  localparam bit                 ONE_FRAME = (DEBOUNCE_FRAMES == 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRESS_DB,
    ST_HELD,
    ST_RELEASE_DB
  } state_t;

  logic [3:0]         r_row_s1;
  logic [3:0]         r_row_s2;
  logic [DIV_W-1:0]   r_div;
  logic [1:0]         r_col;
  logic [KP_KEYS-1:0] r_snap;
  state_t             r_state;
  logic [3:0]         r_cand;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_valid;
  logic [3:0]         r_value;
  logic               r_held;

  logic               w_slot_last;
  logic               w_frame_end;
  logic [KP_KEYS-1:0] w_snap_next;
  logic [3:0]         w_code;
  logic               w_none;
  logic               w_multi;
  logic               w_single;
  logic [CNT_W-1:0]   w_cnt_inc;
  state_t             w_state_nxt;
  logic [3:0]         w_cand_nxt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic               w_valid_nxt;
  logic [3:0]         w_value_nxt;
  logic               w_held_nxt;

  // Two-flop synchronizer; idle level is all rows high (no key).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_row_s1 <= 4'hF;
      r_row_s2 <= 4'hF;
    end else begin
      r_row_s1 <= key_row;
      r_row_s2 <= r_row_s1;
    end
  end

  assign w_slot_last = (r_div == DIV_LAST);
  assign w_frame_end = w_slot_last && (r_col == 2'd2);

  // Slot divider and column index; both restart cleanly, neither can wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div <= '0;
      r_col <= 2'd0;
    end else if (w_slot_last) begin
      r_div <= '0;
      r_col <= (r_col >= 2'd2) ? 2'd0 : r_col + 2'd1;
    end else begin
      r_div <= r_div + 1'b1;
    end
  end

  // Active-low column drive decoded from the column index.
  always_comb begin
    case (r_col)
      2'd0:    key_col = 3'b110;
      2'd1:    key_col = 3'b101;
      default: key_col = 3'b011;
    endcase
  end

  // Snapshot with the current column's rows merged in (active-high pressed).
  always_comb begin
    w_snap_next = r_snap;
    for (int r = 0; r < KP_ROWS; r++) begin
      case (r_col)
        2'd0:    w_snap_next[3*r]     = ~r_row_s2[r];
        2'd1:    w_snap_next[3*r + 1] = ~r_row_s2[r];
        default: w_snap_next[3*r + 2] = ~r_row_s2[r];
      endcase
    end
  end

  // Capture the rows for this column on the last cycle of its slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_snap <= '0;
    end else if (w_slot_last) begin
      r_snap <= w_snap_next;
    end
  end

  // The encoder sees the completed frame on the same edge column 2 is sampled.
  keypad_encoder u_encoder (
    .i_snap  (w_snap_next),
    .o_code  (w_code),
    .o_none  (w_none),
    .o_multi (w_multi)
  );

  assign w_single  = !w_none && !w_multi;
  assign w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;

  // Debounce FSM state and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cand  <= 4'd0;
      r_cnt   <= '0;
      r_valid <= 1'b0;
      r_value <= 4'd0;
      r_held  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cand  <= w_cand_nxt;
      r_cnt   <= w_cnt_nxt;
      r_valid <= w_valid_nxt;
      r_value <= w_value_nxt;
      r_held  <= w_held_nxt;
    end
  end

  // Next-state logic; decisions are taken only at frame end.
  always_comb begin
    w_state_nxt = r_state;
    w_cand_nxt  = r_cand;
    w_cnt_nxt   = r_cnt;
    w_valid_nxt = 1'b0;
    w_value_nxt = r_value;
    w_held_nxt  = r_held;
    if (w_frame_end) begin
      case (r_state)
        ST_IDLE: begin
          if (w_single) begin
            w_cand_nxt = w_code;
            if (ONE_FRAME) begin
              w_state_nxt = ST_HELD;
              w_valid_nxt = 1'b1;
              w_value_nxt = w_code;
              w_held_nxt  = 1'b1;
              w_cnt_nxt   = '0;
            end else begin
              w_state_nxt = ST_PRESS_DB;
              w_cnt_nxt   = CNT_ONE;
            end
          end
        end
        ST_PRESS_DB: begin
          if (w_single && (w_code == r_cand)) begin
            if (w_cnt_inc >= CNT_DONE) begin
              w_state_nxt = ST_HELD;
              w_valid_nxt = 1'b1;
              w_value_nxt = r_cand;
              w_held_nxt  = 1'b1;
              w_cnt_nxt   = '0;
            end else begin
              w_cnt_nxt = w_cnt_inc;
            end
          end else begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
          end
        end
        ST_HELD: begin
          if (w_none) begin
            if (ONE_FRAME) begin
              w_state_nxt = ST_IDLE;
              w_held_nxt  = 1'b0;
              w_cnt_nxt   = '0;
            end else begin
              w_state_nxt = ST_RELEASE_DB;
              w_cnt_nxt   = CNT_ONE;
            end
          end
        end
        ST_RELEASE_DB: begin
          if (w_none) begin
            if (w_cnt_inc >= CNT_DONE) begin
              w_state_nxt = ST_IDLE;
              w_held_nxt  = 1'b0;
              w_cnt_nxt   = '0;
            end else begin
              w_cnt_nxt = w_cnt_inc;
            end
          end else begin
            w_state_nxt = ST_HELD;
            w_cnt_nxt   = '0;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  assign key_valid = r_valid;
  assign key_value = r_value;
  assign key_held  = r_held;

endmodule
